car_controller: RTL and testbench

Car-side controller for the three-floor elevator. It latches hall/car call buttons into the request LEDs and consumes the goal floor `gf` produced by the goal selector. It moves the car one floor per travel period, opens the door on arrival and clears the served request. It drives the `floor`, `led1..3` and `moving` signals that the goal selector reads, closing the loop from the other side of that interface.

---
 rtl/elevator_pkg.sv | 19 +
 rtl/car_controller_call_register.sv | 21 ++
 rtl/car_controller.sv | 112 +++++++++++
 tb/tb_car_controller.sv | 125 ++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: floor labels, FSM states, direction constants and label-space helpers shared by the elevator blocks
package elevator_pkg;
  localparam logic [1:0] F1_DEF = 2'b00;
  localparam logic [1:0] F2_DEF = 2'b01;
  localparam logic [1:0] F3_DEF = 2'b10;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
  function automatic logic [1:0] next_floor(input logic [1:0] cur, input logic up,
                                            input logic [1:0] f1, input logic [1:0] f2, input logic [1:0] f3);
    if (up) return cur == f1 ? f2 : cur == f2 ? f3 : cur;
    return cur == f3 ? f2 : cur == f2 ? f1 : cur;
  endfunction
  // One-hot floor position; also orders floors, so a numeric compare gives direction.
  function automatic logic [2:0] onehot(input logic [1:0] lbl,
                                        input logic [1:0] f1, input logic [1:0] f2, input logic [1:0] f3);
    return {lbl == f3, lbl == f2, lbl == f1};
  endfunction
endpackage

// File: rtl/car_controller_call_register.sv
// call_register: request LED flops; a press at the stopped car's floor is absorbed and clear beats set
module call_register
  import elevator_pkg::*;
#(
  parameter logic [1:0] LABEL_F1 = F1_DEF,
  parameter logic [1:0] LABEL_F2 = F2_DEF,
  parameter logic [1:0] LABEL_F3 = F3_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn,
  input  logic [1:0] floor,
  input  logic       stopped,
  input  logic [2:0] clr,
  output logic [2:0] led
);
  logic [2:0] here;
  assign here = stopped ? onehot(floor, LABEL_F1, LABEL_F2, LABEL_F3) : 3'b000;
  always_ff @(posedge clk)
    led <= rst ? 3'b000 : (led | (btn & ~here)) & ~clr;
endmodule

// File: rtl/car_controller.sv
// car_controller: car FSM (IDLE/MOVE/DOOR) with travel counter, door timer and latched target.
// Optional ELEVATOR_ESTOP_EN adds an estop input that freezes travel, departure and the door timer.
module car_controller
  import elevator_pkg::*;
#(
  parameter logic [1:0] LABEL_F1 = F1_DEF,
  parameter logic [1:0] LABEL_F2 = F2_DEF,
  parameter logic [1:0] LABEL_F3 = F3_DEF,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
`ifdef ELEVATOR_ESTOP_EN
  input  logic       estop,
`endif
  input  logic [1:0] gf,
  output logic [1:0] floor,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic       moving,
  output logic       door_open
);
  localparam int TW = $clog2(TRAVEL_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  state_t state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [1:0] tgt, tgt_n, floor_n, step;
  logic [2:0] led, clr, at;
  logic up, up_n, hold, gf_ok, here, go, serve, tick, arrive;
`ifdef ELEVATOR_ESTOP_EN
  assign hold = estop;
`else
  assign hold = 1'b0;
`endif
  assign {led3, led2, led1} = led;
  assign at = onehot(floor, LABEL_F1, LABEL_F2, LABEL_F3);
  assign gf_ok = |onehot(gf, LABEL_F1, LABEL_F2, LABEL_F3);
  assign here = state != MOVE && |({btn3, btn2, btn1} & at);
  assign go = gf_ok && gf != floor && |led && !hold;
  assign serve = gf == floor && |(led & at);
  assign step = next_floor(floor, up, LABEL_F1, LABEL_F2, LABEL_F3);
  assign tick = state == MOVE && !hold && cnt == TW'(TRAVEL_CYCLES - 1);
  assign arrive = tick && step == tgt;
  assign moving = state == MOVE && !hold;
  assign door_open = state == DOOR;
  // Every DOOR entry clears the LED of the floor the door opens on.
  assign clr = arrive ? onehot(step, LABEL_F1, LABEL_F2, LABEL_F3) :
               (state == IDLE && (here || serve)) ? at : 3'b000;
  call_register #(.LABEL_F1(LABEL_F1), .LABEL_F2(LABEL_F2), .LABEL_F3(LABEL_F3)) u_calls (
    .clk    (clk),
    .rst    (rst),
    .btn    ({btn3, btn2, btn1}),
    .floor  (floor),
    .stopped(state != MOVE),
    .clr    (clr),
    .led    (led)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dcnt_n = dcnt;
    tgt_n = tgt;
    up_n = up;
    floor_n = floor;
    if (state == IDLE) begin
      if (here || serve) begin
        state_n = DOOR;
        dcnt_n = '0;
      end else if (go) begin
        state_n = MOVE;
        cnt_n = '0;
        tgt_n = gf;
        up_n = onehot(gf, LABEL_F1, LABEL_F2, LABEL_F3) > at ? DIR_UP : DIR_DN;
      end
    end else if (state == MOVE) begin
      if (!hold) cnt_n = tick ? '0 : cnt + 1'b1;
      if (tick) floor_n = step;
      if (arrive) begin
        state_n = DOOR;
        dcnt_n = '0;
      end
    end else begin
      if (here) dcnt_n = '0;
      else if (!hold) begin
        dcnt_n = dcnt == DW'(DOOR_CYCLES - 1) ? '0 : dcnt + 1'b1;
        state_n = dcnt == DW'(DOOR_CYCLES - 1) ? IDLE : DOOR;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dcnt <= '0;
      tgt <= LABEL_F1;
      up <= DIR_UP;
      floor <= LABEL_F1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dcnt <= dcnt_n;
      tgt <= tgt_n;
      up <= up_n;
      floor <= floor_n;
    end
endmodule

// File: tb/tb_car_controller.sv
// tb_car_controller: randomized closed-loop bench; a timer-based car model feeds a scoreboard checked every cycle
module tb_car_controller;
  localparam int T = 4;
  localparam int D = 3;
  typedef struct packed {logic [1:0] f; logic [2:0] l; logic m; logic d;} exp_t;
  logic clk = 0, rst = 1, estop = 0, inv = 0, started = 0;
  logic [2:0] bt = 3'b000;
  logic btn1, btn2, btn3, led1, led2, led3, moving, door_open;
  logic [1:0] gf, floor;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  int pos, mode, tgt, tl, dl, g;
  logic [2:0] pend, np;
  bit here;
  assign {btn3, btn2, btn1} = bt;
  always #5 clk = ~clk;
  car_controller dut (
    .clk(clk), .rst(rst), .btn1(btn1), .btn2(btn2), .btn3(btn3),
`ifdef ELEVATOR_ESTOP_EN
    .estop(estop),
`endif
    .gf(gf), .floor(floor), .led1(led1), .led2(led2), .led3(led3),
    .moving(moving), .door_open(door_open)
  );
  // Goal selector stand-in: current floor if requested, else nearest request, ties go up.
  function automatic int goal(int p, logic [2:0] r);
    if (r[p]) return p;
    for (int d = 1; d < 3; d++) begin
      if (p + d < 3 && r[p+d]) return p + d;
      if (p - d >= 0 && r[p-d]) return p - d;
    end
    return p;
  endfunction
  always_comb gf = inv ? 2'b11 : (floor > 2'd2 ? 2'b11 : 2'(goal(int'(floor), {led3, led2, led1})));
  // Reference car: mode 0 idle, 1 travelling, 2 door; tl/dl count down edges left.
  always @(posedge clk) begin
    if (rst) begin
      pos = 0; mode = 0; tgt = 0; tl = 0; dl = 0; pend = 3'b000;
    end else begin
      g = inv ? 3 : goal(pos, pend);
      here = mode != 1 && bt[pos];
      np = pend | bt;
      if (here) np[pos] = pend[pos];
      if (mode == 0) begin
        if (here || (g == pos && pend[pos])) begin
          mode = 2; dl = D; np[pos] = 1'b0;
        end else if (g < 3 && g != pos && pend != 3'b000 && !estop) begin
          mode = 1; tgt = g; tl = T;
        end
      end else if (mode == 1) begin
        if (!estop) tl--;
        if (tl == 0) begin
          pos += tgt > pos ? 1 : -1;
          tl = T;
          if (pos == tgt) begin
            mode = 2; dl = D; np[pos] = 1'b0;
          end
        end
      end else begin
        if (here) dl = D;
        else if (!estop) begin
          dl--;
          if (dl == 0) mode = 0;
        end
      end
      pend = np;
    end
    q.push_back('{2'(pos), pend, mode == 1, mode == 2});
    started = 1;
  end
  always @(negedge clk) if (started) begin
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expected entry at %0t", $time);
    end else begin
      e = q.pop_front();
      checks++;
      if ({floor, led3, led2, led1, moving, door_open} !== {e.f, e.l, e.m && !estop, e.d}) begin
        errors++;
        $display("FAIL outputs @%0t: got floor=%b leds=%b moving=%b door=%b, required floor=%b leds=%b moving=%b door=%b",
                 $time, floor, {led3, led2, led1}, moving, door_open, e.f, e.l, e.m && !estop, e.d);
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(input int f);
    bt = 3'(1 << f);
    cyc(1);
    bt = 3'b000;
  endtask
  initial begin
    #1;
    cyc(2);
    rst = 0;
    press(2); cyc(20);
    press(0); cyc(25);
    press(0); cyc(1); press(0); cyc(8);
    press(2); cyc(6); press(1); cyc(40);
    rst = 1; cyc(1); rst = 0;
    inv = 1; press(1); cyc(30); inv = 0; cyc(20);
    press(2); cyc(6); rst = 1; cyc(1); rst = 0; cyc(3);
`ifdef ELEVATOR_ESTOP_EN
    press(2); cyc(3); estop = 1; cyc(5); estop = 0; cyc(25);
`endif
    for (int i = 0; i < 3000; i++) begin
      bt = {$urandom_range(9) == 0, $urandom_range(9) == 0, $urandom_range(9) == 0};
      if ($urandom_range(49) == 0) inv = ~inv;
      rst = $urandom_range(399) == 0;
`ifdef ELEVATOR_ESTOP_EN
      if ($urandom_range(29) == 0) estop = ~estop;
`endif
      cyc(1);
    end
    bt = 3'b000; inv = 0; rst = 0; estop = 0;
    cyc(60);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
